// File: rtl/execute_md_if.sv
// EX-stage input bundle and EX/MEM register output bundle for execute_md.
interface execute_md_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned REGW  = 5
);
    // ID/EX side
    logic             EX_valid;
    logic             EX_flush;
    logic [1:0]       EX_ctlwb;
    logic [2:0]       EX_ctlm;
    logic [3:0]       EX_ctlex;
    logic [2:0]       EX_md_op;
    logic [WIDTH-1:0] EX_npc;
    logic [WIDTH-1:0] EX_rd1;
    logic [WIDTH-1:0] EX_rd2;
    logic [WIDTH-1:0] EX_imm;
    logic [REGW-1:0]  EX_rt;
    logic [REGW-1:0]  EX_rd;
    logic             EX_stall;

    // EX/MEM side
    logic             MEM_valid;
    logic [WIDTH-1:0] MEM_bpc;
    logic [WIDTH-1:0] MEM_alu_out;
    logic [WIDTH-1:0] MEM_rd2;
    logic [1:0]       MEM_ctlwb;
    logic [2:0]       MEM_ctlm;
    logic             MEM_alu_zero;
    logic [REGW-1:0]  MEM_rd;

    modport master (
        output EX_valid, EX_flush, EX_ctlwb, EX_ctlm, EX_ctlex, EX_md_op,
               EX_npc, EX_rd1, EX_rd2, EX_imm, EX_rt, EX_rd,
        input  EX_stall, MEM_valid, MEM_bpc, MEM_alu_out, MEM_rd2,
               MEM_ctlwb, MEM_ctlm, MEM_alu_zero, MEM_rd
    );

    modport slave (
        input  EX_valid, EX_flush, EX_ctlwb, EX_ctlm, EX_ctlex, EX_md_op,
               EX_npc, EX_rd1, EX_rd2, EX_imm, EX_rt, EX_rd,
        output EX_stall, MEM_valid, MEM_bpc, MEM_alu_out, MEM_rd2,
               MEM_ctlwb, MEM_ctlm, MEM_alu_zero, MEM_rd
    );
endinterface

// File: rtl/execute_md.sv
// MIPS execute stage with iterative unsigned MULTU/DIVU, HI/LO and EX/MEM register.
module execute_md #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned REGW  = 5
) (
    input  logic        clk,
    input  logic        rst,
    execute_md_if.slave bus
);
    localparam int unsigned CNTW = $clog2(WIDTH + 1);

    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIVU  = 3'b010;
    localparam logic [2:0] MD_MFHI  = 3'b011;
    localparam logic [2:0] MD_MFLO  = 3'b100;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             is_div_q, is_div_d;

    logic             start_c, last_c, stall_c, bubble_c;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff, iter_rem;
    logic [WIDTH-1:0] iter_quo;

    logic [WIDTH-1:0] alu_in2, alu_res, result, bpc;
    logic [REGW-1:0]  rd_mux;

    logic             mem_valid_q, mem_zero_q;
    logic [WIDTH-1:0] mem_bpc_q, mem_alu_q, mem_rd2_q;
    logic [1:0]       mem_ctlwb_q;
    logic [2:0]       mem_ctlm_q;
    logic [REGW-1:0]  mem_rd_q;

    // MD state register: FSM, iteration counter, working registers, HI/LO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
        end
    end

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        mul_sum   = rem_q + (quo_q[0] ? {1'b0, dvs_q} : '0);
        div_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, dvs_q};
        iter_rem  = {1'b0, mul_sum[WIDTH:1]};
        iter_quo  = {mul_sum[0], quo_q[WIDTH-1:1]};
        if (is_div_q) begin
            // Borrow out of the top bit means the trial subtraction failed: restore
            if (!div_diff[WIDTH]) begin
                iter_rem = div_diff;
                iter_quo = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                iter_rem = div_shift;
                iter_quo = {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // MD next-state: start, iterate, commit HI/LO on the last iteration, abort on flush
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    state_d  = S_BUSY;
                    cnt_d    = CNTW'(WIDTH);
                    rem_d    = '0;
                    quo_d    = bus.EX_rd1;
                    dvs_d    = bus.EX_rd2;
                    is_div_d = (bus.EX_md_op == MD_DIVU);
                end
            end
            S_BUSY: begin
                if (bus.EX_flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                    rem_d = iter_rem;
                    quo_d = iter_quo;
                    if (last_c) begin
                        state_d = S_IDLE;
                        hi_d    = iter_rem[WIDTH-1:0];
                        lo_d    = iter_quo;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // MD outputs: start detect, last iteration, upstream stall, bubble insertion
    always_comb begin
        start_c  = !rst && (state_q == S_IDLE) && bus.EX_valid && !bus.EX_flush &&
                   ((bus.EX_md_op == MD_MULTU) || (bus.EX_md_op == MD_DIVU));
        last_c   = (state_q == S_BUSY) && (cnt_q == CNTW'(1));
        stall_c  = !rst && !bus.EX_flush &&
                   (start_c || ((state_q == S_BUSY) && (cnt_q > CNTW'(1))));
        bubble_c = !bus.EX_valid || bus.EX_flush || stall_c;
    end

    // ALU, HI/LO forwarding, branch target and destination select
    always_comb begin
        alu_in2 = bus.EX_ctlex[0] ? bus.EX_imm : bus.EX_rd2;
        unique case (bus.EX_ctlex[2:1])
            2'b00: alu_res = bus.EX_rd1 + alu_in2;
            2'b01: alu_res = bus.EX_rd1 - alu_in2;
            2'b11: alu_res = bus.EX_rd1 | alu_in2;
            default: begin
                unique case (bus.EX_imm[5:0])
                    6'h22:   alu_res = bus.EX_rd1 - alu_in2;
                    6'h24:   alu_res = bus.EX_rd1 & alu_in2;
                    6'h25:   alu_res = bus.EX_rd1 | alu_in2;
                    6'h2A:   alu_res = ($signed(bus.EX_rd1) < $signed(alu_in2)) ? WIDTH'(1) : '0;
                    default: alu_res = bus.EX_rd1 + alu_in2;
                endcase
            end
        endcase
        if (bus.EX_md_op == MD_MFHI) begin
            result = hi_q;
        end else if (bus.EX_md_op == MD_MFLO) begin
            result = lo_q;
        end else begin
            result = alu_res;
        end
        bpc    = bus.EX_npc + (bus.EX_imm << 2);
        rd_mux = bus.EX_ctlex[3] ? bus.EX_rd : bus.EX_rt;
    end

    // EX/MEM pipeline register: loads every cycle, controls zeroed on a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid_q <= 1'b0;
            mem_ctlwb_q <= '0;
            mem_ctlm_q  <= '0;
            mem_bpc_q   <= '0;
            mem_alu_q   <= '0;
            mem_rd2_q   <= '0;
            mem_zero_q  <= 1'b0;
            mem_rd_q    <= '0;
        end else begin
            mem_valid_q <= !bubble_c;
            mem_ctlwb_q <= bubble_c ? 2'b00  : bus.EX_ctlwb;
            mem_ctlm_q  <= bubble_c ? 3'b000 : bus.EX_ctlm;
            mem_bpc_q   <= bpc;
            mem_alu_q   <= result;
            mem_rd2_q   <= bus.EX_rd2;
            mem_zero_q  <= (result == '0);
            mem_rd_q    <= rd_mux;
        end
    end

    assign bus.EX_stall     = stall_c;
    assign bus.MEM_valid    = mem_valid_q;
    assign bus.MEM_ctlwb    = mem_ctlwb_q;
    assign bus.MEM_ctlm     = mem_ctlm_q;
    assign bus.MEM_bpc      = mem_bpc_q;
    assign bus.MEM_alu_out  = mem_alu_q;
    assign bus.MEM_rd2      = mem_rd2_q;
    assign bus.MEM_alu_zero = mem_zero_q;
    assign bus.MEM_rd       = mem_rd_q;
endmodule

// File: tb/tb_execute_md.sv
// Self-checking bench for execute_md: directed vector table, multi-cycle MD sequences, random stimulus.
module tb_execute_md;
    localparam int unsigned W = 32;
    localparam int unsigned R = 5;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    execute_md_if #(.WIDTH(W), .REGW(R)) bus_if ();
    execute_md #(.WIDTH(W), .REGW(R)) dut (.clk(clk), .rst(rst), .bus(bus_if));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        valid;
        logic        flush;
        logic [3:0]  ctlex;
        logic [2:0]  md;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] npc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        e_valid;
        logic [31:0] e_alu;
        logic        e_zero;
        logic [31:0] e_bpc;
        logic [4:0]  e_rd;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic [3:0] ctlex, input logic [2:0] md,
                         input logic [1:0] wb, input logic [2:0] m, input logic [31:0] npc,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [4:0] rt, input logic [4:0] rd);
        bus_if.EX_valid = v;
        bus_if.EX_flush = f;
        bus_if.EX_ctlex = ctlex;
        bus_if.EX_md_op = md;
        bus_if.EX_ctlwb = wb;
        bus_if.EX_ctlm  = m;
        bus_if.EX_npc   = npc;
        bus_if.EX_rd1   = a;
        bus_if.EX_rd2   = b;
        bus_if.EX_imm   = imm;
        bus_if.EX_rt    = rt;
        bus_if.EX_rd    = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU written directly from the instruction semantics
    function automatic logic [31:0] alu_ref(input logic [3:0] ctlex, input logic [2:0] md,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] imm);
        logic [31:0] y;
        logic [31:0] r;
        y = ctlex[0] ? imm : b;
        case (ctlex[2:1])
            2'd0: r = a + y;
            2'd1: r = a - y;
            2'd3: r = a | y;
            default: begin
                case (imm[5:0])
                    6'h22:   r = a - y;
                    6'h24:   r = a & y;
                    6'h25:   r = a | y;
                    6'h2A:   r = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
                    default: r = a + y;
                endcase
            end
        endcase
        if (md == 3'd3) r = hi_m;
        if (md == 3'd4) r = lo_m;
        return r;
    endfunction

    task automatic md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        if (op == 3'd1) begin
            p    = 64'(a) * 64'(b);
            hi_m = p[63:32];
            lo_m = p[31:0];
        end else if (b == 32'd0) begin
            lo_m = 32'hFFFF_FFFF;
            hi_m = a;
        end else begin
            lo_m = a / b;
            hi_m = a % b;
        end
    endtask

    // Issue MULTU/DIVU and hold it until it leaves EX; counts stall cycles and bubbles
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int stalls;
        int bubbles;
        bit done;
        drive(1'b1, 1'b0, 4'b1100, op, 2'b10, 3'b000, 32'h40, a, b, 32'h20, 5'd1, 5'd2);
        stalls  = 0;
        bubbles = 0;
        done    = 1'b0;
        for (int c = 0; c < int'(W) + 8 && !done; c++) begin
            #1;
            if (bus_if.EX_stall) stalls++;
            @(posedge clk);
            #1;
            if (bus_if.MEM_valid) done = 1'b1;
            else bubbles++;
        end
        check("md_stall_cycles", 64'(stalls), 64'(W));
        check("md_bubbles", 64'(bubbles), 64'(W));
        check("md_completed", 64'(done), 64'(1));
        md_ref(op, a, b);
    endtask

    task automatic mf(input bit sel_hi, input logic [31:0] exp, input string name);
        drive(1'b1, 1'b0, 4'b1100, sel_hi ? 3'd3 : 3'd4, 2'b10, 3'b000, 32'h0,
              $urandom, $urandom, 32'h20, 5'd1, 5'd2);
        step();
        check({name, "_valid"}, 64'(bus_if.MEM_valid), 64'(1));
        check(name, 64'(bus_if.MEM_alu_out), 64'(exp));
    endtask

    function automatic vec_t mk(input logic v, input logic f, input logic [3:0] ctlex, input logic [2:0] md,
                                input logic [1:0] wb, input logic [2:0] m, input logic [31:0] npc,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                input logic [4:0] rt, input logic [4:0] rd, input logic ev,
                                input logic [31:0] ealu, input logic ez, input logic [31:0] ebpc,
                                input logic [4:0] erd);
        vec_t t;
        t.valid = v;   t.flush = f;   t.ctlex = ctlex; t.md = md;   t.wb = wb; t.m = m;
        t.npc = npc;   t.a = a;       t.b = b;         t.imm = imm; t.rt = rt; t.rd = rd;
        t.e_valid = ev; t.e_alu = ealu; t.e_zero = ez; t.e_bpc = ebpc; t.e_rd = erd;
        return t;
    endfunction

    initial begin
        vec_t tbl[14];
        logic [2:0]  mds[6];
        logic [2:0]  op;
        logic [31:0] ra, rb, rimm, rnpc, exp_alu;
        logic [3:0]  rctl;
        logic [2:0]  rmd, rm;
        logic [1:0]  rwb;
        logic [4:0]  rrt, rrd;
        logic        rv, rf, bub;
        logic [5:0]  functs[6];

        n_checks = 0;
        n_errors = 0;
        hi_m = 32'd0;
        lo_m = 32'd0;
        mds    = '{3'd0, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};

        //            v     f     ctlex    md    wb     m       npc      a             b             imm           rt     rd      ev    alu           z     bpc           rd
        tbl[0]  = mk(1'b1, 1'b0, 4'b1100, 3'd0, 2'b10, 3'b000, 32'h40,  32'd5,        32'd7,        32'h20,       5'd2,  5'd3,  1'b1, 32'd12,       1'b0, 32'hC0,       5'd3);
        tbl[1]  = mk(1'b1, 1'b0, 4'b0010, 3'd0, 2'b00, 3'b100, 32'h100, 32'd9,        32'd9,        32'd4,        5'd4,  5'd6,  1'b1, 32'd0,        1'b1, 32'h110,      5'd4);
        tbl[2]  = mk(1'b1, 1'b0, 4'b1100, 3'd0, 2'b10, 3'b000, 32'h0,   32'd10,       32'd3,        32'h22,       5'd1,  5'd7,  1'b1, 32'd7,        1'b0, 32'h88,       5'd7);
        tbl[3]  = mk(1'b1, 1'b0, 4'b1100, 3'd0, 2'b10, 3'b000, 32'h0,   32'hF0F0,     32'h0FF0,     32'h24,       5'd1,  5'd8,  1'b1, 32'h00F0,     1'b0, 32'h90,       5'd8);
        tbl[4]  = mk(1'b1, 1'b0, 4'b1100, 3'd0, 2'b10, 3'b000, 32'h0,   32'hF000,     32'h000F,     32'h25,       5'd1,  5'd9,  1'b1, 32'hF00F,     1'b0, 32'h94,       5'd9);
        tbl[5]  = mk(1'b1, 1'b0, 4'b1100, 3'd0, 2'b10, 3'b000, 32'h0,   32'hFFFFFFFF, 32'd1,        32'h2A,       5'd1,  5'd10, 1'b1, 32'd1,        1'b0, 32'hA8,       5'd10);
        tbl[6]  = mk(1'b1, 1'b0, 4'b1100, 3'd0, 2'b10, 3'b000, 32'h0,   32'd1,        32'hFFFFFFFF, 32'h2A,       5'd1,  5'd11, 1'b1, 32'd0,        1'b1, 32'hA8,       5'd11);
        tbl[7]  = mk(1'b1, 1'b0, 4'b1100, 3'd0, 2'b10, 3'b000, 32'h0,   32'd2,        32'd3,        32'h3F,       5'd1,  5'd12, 1'b1, 32'd5,        1'b0, 32'hFC,       5'd12);
        tbl[8]  = mk(1'b1, 1'b0, 4'b0111, 3'd0, 2'b10, 3'b000, 32'h1000,32'h0F00,     32'hDEAD,     32'h00F0,     5'd13, 5'd14, 1'b1, 32'h0FF0,     1'b0, 32'h13C0,     5'd13);
        tbl[9]  = mk(1'b1, 1'b0, 4'b0001, 3'd0, 2'b10, 3'b000, 32'h200, 32'd100,      32'd0,        32'hFFFFFFFC, 5'd15, 5'd1,  1'b1, 32'd96,       1'b0, 32'h1F0,      5'd15);
        tbl[10] = mk(1'b0, 1'b0, 4'b1100, 3'd0, 2'b11, 3'b111, 32'h0,   32'd1,        32'd1,        32'h20,       5'd1,  5'd2,  1'b0, 32'd0,        1'b0, 32'h0,        5'd0);
        tbl[11] = mk(1'b1, 1'b1, 4'b1100, 3'd0, 2'b11, 3'b111, 32'h0,   32'd1,        32'd1,        32'h20,       5'd1,  5'd2,  1'b0, 32'd0,        1'b0, 32'h0,        5'd0);
        tbl[12] = mk(1'b1, 1'b0, 4'b0010, 3'd0, 2'b01, 3'b010, 32'h0,   32'd3,        32'd5,        32'h0,        5'd16, 5'd17, 1'b1, 32'hFFFFFFFE, 1'b0, 32'h0,        5'd16);
        tbl[13] = mk(1'b1, 1'b0, 4'b1100, 3'd3, 2'b10, 3'b000, 32'h0,   32'd5,        32'd7,        32'h20,       5'd2,  5'd3,  1'b1, 32'd0,        1'b1, 32'h80,       5'd3);

        // Reset state
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'b0, 3'd0, 2'b0, 3'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        step();
        check("rst_valid", 64'(bus_if.MEM_valid), 64'(0));
        check("rst_stall", 64'(bus_if.EX_stall), 64'(0));
        check("rst_ctlwb", 64'(bus_if.MEM_ctlwb), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].valid, tbl[i].flush, tbl[i].ctlex, tbl[i].md, tbl[i].wb, tbl[i].m,
                  tbl[i].npc, tbl[i].a, tbl[i].b, tbl[i].imm, tbl[i].rt, tbl[i].rd);
            step();
            check($sformatf("vec%0d_valid", i), 64'(bus_if.MEM_valid), 64'(tbl[i].e_valid));
            check($sformatf("vec%0d_ctlwb", i), 64'(bus_if.MEM_ctlwb), tbl[i].e_valid ? 64'(tbl[i].wb) : 64'(0));
            check($sformatf("vec%0d_ctlm", i), 64'(bus_if.MEM_ctlm), tbl[i].e_valid ? 64'(tbl[i].m) : 64'(0));
            if (tbl[i].e_valid) begin
                check($sformatf("vec%0d_alu", i), 64'(bus_if.MEM_alu_out), 64'(tbl[i].e_alu));
                check($sformatf("vec%0d_zero", i), 64'(bus_if.MEM_alu_zero), 64'(tbl[i].e_zero));
                check($sformatf("vec%0d_bpc", i), 64'(bus_if.MEM_bpc), 64'(tbl[i].e_bpc));
                check($sformatf("vec%0d_rd", i), 64'(bus_if.MEM_rd), 64'(tbl[i].e_rd));
                check($sformatf("vec%0d_rd2", i), 64'(bus_if.MEM_rd2), 64'(tbl[i].b));
            end
        end

        // MULTU all-ones x 2, then MFHI/MFLO back to back
        run_md(3'd1, 32'hFFFF_FFFF, 32'd2);
        mf(1'b1, 32'h0000_0001, "multu_hi");
        mf(1'b0, 32'hFFFF_FFFE, "multu_lo");

        // DIVU, including divide by zero
        run_md(3'd2, 32'd100, 32'd7);
        mf(1'b0, 32'd14, "divu_lo");
        mf(1'b1, 32'd2, "divu_hi");
        run_md(3'd2, 32'h55, 32'd0);
        mf(1'b0, 32'hFFFF_FFFF, "div0_lo");
        mf(1'b1, 32'h55, "div0_hi");

        // Back-to-back MULTU
        run_md(3'd1, 32'd1234567, 32'd7654321);
        run_md(3'd1, 32'h8000_0001, 32'hFFFF_FFFF);
        mf(1'b1, hi_m, "b2b_hi");
        mf(1'b0, lo_m, "b2b_lo");

        // Flush mid-MULTU: preload HI=LO=0x1234 via DIVU
        run_md(3'd2, 32'h0246_9234, 32'h0000_2000);
        drive(1'b1, 1'b0, 4'b1100, 3'd1, 2'b10, 3'b000, 32'h0, 32'd3, 32'd5, 32'h20, 5'd1, 5'd2);
        for (int c = 0; c < 10; c++) step();
        bus_if.EX_flush = 1'b1;
        #1;
        check("flush_stall", 64'(bus_if.EX_stall), 64'(0));
        step();
        check("flush_valid", 64'(bus_if.MEM_valid), 64'(0));
        drive(1'b1, 1'b0, 4'b1100, 3'd4, 2'b10, 3'b000, 32'h0, 32'd0, 32'd0, 32'h20, 5'd1, 5'd2);
        #1;
        check("flush_idle_stall", 64'(bus_if.EX_stall), 64'(0));
        step();
        check("flush_lo", 64'(bus_if.MEM_alu_out), 64'(32'h1234));
        mf(1'b1, 32'h1234, "flush_hi");

        // Reset in the middle of a DIVU, between clock edges
        drive(1'b1, 1'b0, 4'b1100, 3'd2, 2'b11, 3'b111, 32'h44, 32'd1000, 32'd3, 32'h20, 5'd1, 5'd2);
        for (int c = 0; c < 5; c++) step();
        check("pre_rst_stall", 64'(bus_if.EX_stall), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(bus_if.MEM_valid), 64'(0));
        check("mid_rst_alu", 64'(bus_if.MEM_alu_out), 64'(0));
        check("mid_rst_bpc", 64'(bus_if.MEM_bpc), 64'(0));
        check("mid_rst_rd2", 64'(bus_if.MEM_rd2), 64'(0));
        check("mid_rst_rd", 64'(bus_if.MEM_rd), 64'(0));
        check("mid_rst_stall", 64'(bus_if.EX_stall), 64'(0));
        drive(1'b0, 1'b0, 4'b0, 3'd0, 2'b0, 3'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        step();
        rst  = 1'b0;
        hi_m = 32'd0;
        lo_m = 32'd0;
        mf(1'b1, 32'd0, "post_rst_hi");
        mf(1'b0, 32'd0, "post_rst_lo");

        // Random stimulus against the reference model
        for (int it = 0; it < 120; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                op = 3'($urandom_range(1, 2));
                ra = $urandom;
                rb = ($urandom_range(0, 3) == 0) ? 32'd0 :
                     (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
                run_md(op, ra, rb);
                mf(1'b1, hi_m, "rnd_md_hi");
                mf(1'b0, lo_m, "rnd_md_lo");
            end else begin
                rctl = 4'($urandom);
                rmd  = mds[$urandom_range(0, 5)];
                rwb  = 2'($urandom);
                rm   = 3'($urandom);
                rnpc = $urandom;
                ra   = $urandom;
                rb   = ($urandom_range(0, 3) == 0) ? ra : $urandom;
                rimm = $urandom;
                rimm[5:0] = functs[$urandom_range(0, 5)];
                rrt  = 5'($urandom);
                rrd  = 5'($urandom);
                rv   = ($urandom_range(0, 7) != 0);
                rf   = ($urandom_range(0, 9) == 0);
                bub  = !rv || rf;
                exp_alu = alu_ref(rctl, rmd, ra, rb, rimm);
                drive(rv, rf, rctl, rmd, rwb, rm, rnpc, ra, rb, rimm, rrt, rrd);
                step();
                check("rnd_valid", 64'(bus_if.MEM_valid), 64'(!bub));
                check("rnd_ctlwb", 64'(bus_if.MEM_ctlwb), bub ? 64'(0) : 64'(rwb));
                check("rnd_ctlm", 64'(bus_if.MEM_ctlm), bub ? 64'(0) : 64'(rm));
                if (!bub) begin
                    check("rnd_alu", 64'(bus_if.MEM_alu_out), 64'(exp_alu));
                    check("rnd_zero", 64'(bus_if.MEM_alu_zero), 64'(exp_alu == 32'd0));
                    check("rnd_bpc", 64'(bus_if.MEM_bpc), 64'(32'(rnpc + rimm * 32'd4)));
                    check("rnd_rd", 64'(bus_if.MEM_rd), 64'(rctl[3] ? rrd : rrt));
                    check("rnd_rd2", 64'(bus_if.MEM_rd2), 64'(rb));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/execute_md.md
# execute_md

Parametrised successor to the single-cycle MIPS execute stage, including the EX/MEM pipeline register. It adds an iterative unsigned multiply/divide unit with HI/LO registers, a valid bit, stall and flush handling, and configurable data and register-address widths. It sits between the ID/EX register and the memory stage. When a MULTU or DIVU occupies the unit, it stalls upstream and inserts bubbles downstream.

## Interface
Parameters:
- WIDTH, 32, datapath width. Multiply and divide each take WIDTH iterations.
- REGW, 5, register-address width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- EX_valid  in  1  an instruction is present in EX.
- EX_flush  in  1  squash the EX instruction and abort any multiply/divide in progress.
- EX_ctlwb  in  2  WB controls, passed through.
- EX_ctlm  in  3  MEM controls, passed through.
- EX_ctlex  in  4  [3] reg_dst, [2:1] alu_op, [0] alu_src.
- EX_md_op  in  3  000 none, 001 MULTU, 010 DIVU, 011 MFHI, 100 MFLO; others mean none.
- EX_npc, EX_rd1, EX_rd2, EX_imm  in  WIDTH  next PC, operand A, operand B, sign-extended immediate.
- EX_rt, EX_rd  in  REGW  candidate destination registers.
- EX_stall  out  1  hold IF/ID/EX; upstream keeps every EX_* input stable while this is high.
- MEM_valid  out  1  the MEM-stage instruction is real.
- MEM_bpc, MEM_alu_out, MEM_rd2  out  WIDTH  branch target, result, store data.
- MEM_ctlwb  out  2  registered WB controls.
- MEM_ctlm  out  3  registered MEM controls.
- MEM_alu_zero  out  1  result equals zero.
- MEM_rd  out  REGW  selected destination register.

## Operation
- **Branch target.** bpc = npc + (imm << 2), truncated to WIDTH.
- **Operand B.** alu_in2 = alu_src ? imm : rd2.
- **Destination.** rd_mux = reg_dst ? rd : rt.
- **ALU select.**
  - alu_op 00: add. 01: sub. 11: or.
  - alu_op 10 decodes funct = imm[5:0]: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt (result 1 or 0); any other funct is add.
- **Result.** alu_out is the ALU result, replaced by HI for MFHI and by LO for MFLO. zero = (alu_out == 0).
- **MD FSM states.**
  - IDLE: start when EX_valid & !EX_flush & md_op is MULTU or DIVU. At that edge latch rd1 and rd2, load cnt = WIDTH, go to BUSY.
  - BUSY: one iteration per cycle, cnt decrements. When cnt == 1, write HI/LO at that edge and return to IDLE.
- **MULTU.** Radix-2 shift-add, unsigned. {HI,LO} = 2*WIDTH-bit product.
- **DIVU.** Restoring, unsigned. LO = quotient, HI = remainder.
  - Divide by zero uses the same latency and gives the natural result: LO = all ones, HI = dividend.
- **EX_stall** = (IDLE & start condition) | (BUSY & cnt > 1). It is forced to 0 whenever EX_flush = 1.
- **EX/MEM register load.** Loads every cycle; there is no downstream stall.
  - Bubble condition: !EX_valid | EX_flush | EX_stall.
  - On a bubble: MEM_valid = 0, MEM_ctlwb = 0, MEM_ctlm = 0. Data fields still load their computed values (don't-care).
  - Otherwise: MEM_valid = 1 and control fields are copied.
- **Flush while BUSY.** Go to IDLE. HI/LO are unchanged and the partial result is discarded.
- **Reset (asynchronous, any time, including mid-operation).**
  - All MEM_* outputs = 0.
  - HI = LO = 0, FSM = IDLE, cnt = 0, so EX_stall = 0.

## Timing
- ALU and branch instructions: 1-cycle latency. Inputs in cycle n appear on MEM_* after the rising edge ending cycle n.
- MULTU/DIVU:
  - The instruction is presented in cycle 0. EX_stall is high in cycles 0 through WIDTH-1 (WIDTH cycles) and low in cycle WIDTH.
  - HI/LO update at the edge ending cycle WIDTH.
  - The instruction enters MEM at that same edge with MEM_valid = 1. Bubbles precede it.
  - Total EX occupancy is WIDTH+1 cycles.
- MFHI/MFLO issued immediately after MULTU/DIVU sees the new HI/LO; there is no hazard bubble.
- Back-to-back MULTU: the second one is accepted in the cycle after the first completes, since the FSM is then in IDLE.
- Simultaneous start and flush: no start, bubble issued.
- Reset release: the first edge with rst low behaves as IDLE with EX_valid sampled normally.

## Test plan
- **R-type ADD.** WIDTH=32, ctlex=4'b1100, funct=0x20, rd1=5, rd2=7, rt=2, rd=3, ctlwb=2'b10 -> next edge: MEM_alu_out=12, MEM_rd=3, MEM_alu_zero=0, MEM_valid=1, MEM_ctlwb=2'b10.
- **BEQ taken.** ctlex=4'b0010, rd1=rd2=9, npc=0x100, imm=4 -> MEM_alu_zero=1, MEM_bpc=0x110.
- **MULTU.** MULTU 0xFFFFFFFF × 2 -> EX_stall high exactly 32 cycles and MEM_valid=0 for those cycles. Then MFHI -> MEM_alu_out=1; MFLO -> 0xFFFFFFFE.
- **DIVU.**
  - DIVU 100 / 7 -> LO=14, HI=2.
  - DIVU 0x55 / 0 -> LO=0xFFFFFFFF, HI=0x55, same 33-cycle occupancy.
- **Flush mid-MULTU.** Preload HI=LO=0x1234, start MULTU, assert EX_flush in cycle 10 -> EX_stall=0 that cycle, MEM_valid=0, FSM IDLE, a following MFLO returns 0x1234.
- **Reset mid-DIVU.** Assert rst during cycle 5 of a DIVU, between clock edges -> immediately all MEM_* = 0 and EX_stall = 0. After release, MFHI returns 0.
